// File: rtl/nf_pkg.sv
// Shared types and helpers for neighbour_fetch: block modes, FSM states and
// the corner/top/top-right/left slot ordering shared by requests and responses.
package nf_pkg;

    localparam int CNT_W     = 8;
    localparam int IDX_W     = 8;
    localparam int SLOT_TR_N = 4;

    typedef enum logic [1:0] {
        MODE_16 = 2'd0,
        MODE_8  = 2'd1,
        MODE_4  = 2'd2
    } blk_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Group codes double as the fetch order: corner, top, top-right, left.
    typedef enum logic [1:0] {
        GRP_CORNER = 2'd0,
        GRP_TOP    = 2'd1,
        GRP_TR     = 2'd2,
        GRP_LEFT   = 2'd3
    } grp_e;

    typedef struct packed {
        grp_e             grp;
        logic [IDX_W-1:0] idx;
    } slot_t;

    function automatic logic [CNT_W-1:0] mode_to_n(input logic [1:0] mode);
        case (mode)
            MODE_8:  return CNT_W'(8);
            MODE_4:  return CNT_W'(4);
            default: return CNT_W'(16);
        endcase
    endfunction

    // Map the k-th issued request (unavailable groups removed) to its slot.
    function automatic slot_t req_slot(input logic [CNT_W-1:0] k,
                                       input logic [CNT_W-1:0] n,
                                       input logic c_av,
                                       input logic t_av,
                                       input logic tr_av);
        slot_t            s;
        logic [CNT_W-1:0] r;
        logic             hit;
        r     = k;
        hit   = 1'b0;
        s.grp = GRP_LEFT;
        if (c_av) begin
            if (r == '0) begin
                s.grp = GRP_CORNER;
                hit   = 1'b1;
            end else begin
                r = r - CNT_W'(1);
            end
        end
        if (t_av && !hit) begin
            if (r < n) begin
                s.grp = GRP_TOP;
                hit   = 1'b1;
            end else begin
                r = r - n;
            end
        end
        if (tr_av && !hit) begin
            if (r < CNT_W'(SLOT_TR_N)) begin
                s.grp = GRP_TR;
            end else begin
                r = r - CNT_W'(SLOT_TR_N);
            end
        end
        s.idx = IDX_W'(r);
        return s;
    endfunction

endpackage

// File: rtl/neighbour_fetch_if.sv
// Single-port frame-buffer read bus: in-order responses, no backpressure.
interface neighbour_fetch_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 20
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [PIX_W-1:0]  mem_rdata;

    modport master (output mem_req, mem_addr, input mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_rvalid, mem_rdata);
endinterface

// File: rtl/nf_addr_gen.sv
// Turns the request index into a frame-buffer address and last flag, and the
// response index into the destination slot for the returned pixel.
module nf_addr_gen
    import nf_pkg::*;
#(
    parameter int FRAME_W = 1280,
    parameter int ADDR_W  = 20
) (
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    input  logic [CNT_W-1:0]  n,
    input  logic              corner_av,
    input  logic              top_av,
    input  logic              tr_av,
    input  logic [CNT_W-1:0]  req_idx,
    input  logic [CNT_W-1:0]  rsp_idx,
    input  logic [CNT_W-1:0]  nreq,
    output logic [ADDR_W-1:0] addr,
    output slot_t             rsp_slot,
    output logic              last
);
    localparam int            AW     = ADDR_W + 1;
    localparam logic [AW-1:0] STRIDE = AW'(FRAME_W);

    slot_t         rq;
    logic [AW-1:0] row;
    logic [AW-1:0] col;

    always_comb begin
        rq       = req_slot(req_idx, n, corner_av, top_av, tr_av);
        rsp_slot = req_slot(rsp_idx, n, corner_av, top_av, tr_av);
        row      = AW'(y) - AW'(1);
        col      = AW'(x) - AW'(1);
        unique case (rq.grp)
            GRP_TOP:  col = AW'(x) + AW'(rq.idx);
            GRP_TR:   col = AW'(x) + AW'(n) + AW'(rq.idx);
            GRP_LEFT: row = AW'(y) + AW'(rq.idx);
            default:  ;
        endcase
        addr = ADDR_W'(row * STRIDE + col);
        last = (req_idx == nreq - CNT_W'(1));
    end

endmodule

// File: rtl/neighbour_fetch.sv
// Fetches corner/top/top-right/left intra neighbours for one block over a read bus.
// Top-right pixels are read only when NF_TOPRIGHT_EN is defined; otherwise substituted.
module neighbour_fetch
    import nf_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int FRAME_W     = 1280,
    parameter int FRAME_H     = 720,
    parameter int MAX_N       = 16,
    parameter int ADDR_W      = 20,
    parameter int DEFAULT_PIX = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    blk_mode,
    input  logic [15:0]                   pix_x,
    input  logic [15:0]                   pix_y,
    output logic                          busy,
    output logic                          done,
    neighbour_fetch_if.master             mem,
    output logic [MAX_N-1:0][PIX_W-1:0]   toppixels,
    output logic [3:0][PIX_W-1:0]         toprightpixels,
    output logic [MAX_N-1:0][PIX_W-1:0]   leftpixels,
    output logic [PIX_W-1:0]              cornerpixel,
    output logic                          top_avail,
    output logic                          left_avail,
    output logic                          corner_avail,
    output logic                          topright_avail
);
    localparam int               IW  = $clog2(MAX_N);
    localparam logic [PIX_W-1:0] DEF = PIX_W'(DEFAULT_PIX);

    if ((64'd1 << ADDR_W) < 64'(FRAME_W) * 64'(FRAME_H)) begin : g_addr_w_too_small
        $error("ADDR_W cannot address the whole frame");
    end

    state_e                       state_q, state_d;
    logic [15:0]                  x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]             n_q, n_d, nreq_q, nreq_d, req_q, req_d, rsp_q, rsp_d;
    logic                         busy_q, busy_d, done_q, done_d;
    logic                         t_q, t_d, l_q, l_d, c_q, c_d, tr_q, tr_d;
    logic [MAX_N-1:0][PIX_W-1:0]  top_q, top_d, left_q, left_d;
    logic [3:0][PIX_W-1:0]        trp_q, trp_d;
    logic [PIX_W-1:0]             cor_q, cor_d;

    logic [CNT_W-1:0] n_in, nreq_in;
    logic             t_in, l_in, c_in, tr_in;
    logic [ADDR_W-1:0] req_addr;
    slot_t            rsp_slot;
    logic             req_last;
    logic             req_c;

    nf_addr_gen #(.FRAME_W(FRAME_W), .ADDR_W(ADDR_W)) u_addr_gen (
        .x(x_q), .y(y_q), .n(n_q),
        .corner_av(c_q), .top_av(t_q), .tr_av(tr_q),
        .req_idx(req_q), .rsp_idx(rsp_q), .nreq(nreq_q),
        .addr(req_addr), .rsp_slot(rsp_slot), .last(req_last)
    );

    always_comb begin
        n_in = mode_to_n(blk_mode);
        t_in = (pix_y != 16'd0);
        l_in = (pix_x != 16'd0);
        c_in = t_in && l_in;
`ifdef NF_TOPRIGHT_EN
        tr_in = t_in && (n_in == CNT_W'(4)) &&
                (17'(pix_x) + 17'(n_in) + 17'd3 < 17'(FRAME_W));
`else
        tr_in = 1'b0;
`endif
        nreq_in = CNT_W'(c_in) + (t_in ? n_in : '0) +
                  (tr_in ? CNT_W'(SLOT_TR_N) : '0) + (l_in ? n_in : '0);
    end

    always_comb begin
        state_d = state_q;
        x_d = x_q;  y_d = y_q;  n_d = n_q;  nreq_d = nreq_q;
        req_d = req_q;  rsp_d = rsp_q;
        busy_d = busy_q;  done_d = done_q;
        t_d = t_q;  l_d = l_q;  c_d = c_q;  tr_d = tr_q;
        top_d = top_q;  left_d = left_q;  trp_d = trp_q;  cor_d = cor_q;
        req_c = 1'b0;

        // Responses can overlap the issue phase, so capture in both states.
        if ((state_q == ST_ISSUE || state_q == ST_WAIT) && mem.mem_rvalid && rsp_q != nreq_q) begin
            rsp_d = rsp_q + CNT_W'(1);
            case (rsp_slot.grp)
                GRP_CORNER: cor_d = mem.mem_rdata;
                GRP_TOP: begin
                    top_d[rsp_slot.idx[IW-1:0]] = mem.mem_rdata;
                    if (!tr_q && rsp_slot.idx == IDX_W'(n_q - CNT_W'(1)))
                        trp_d = {4{mem.mem_rdata}};
                end
                GRP_TR:     trp_d[rsp_slot.idx[1:0]] = mem.mem_rdata;
                default:    left_d[rsp_slot.idx[IW-1:0]] = mem.mem_rdata;
            endcase
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
                if (start) begin
                    x_d = pix_x;  y_d = pix_y;  n_d = n_in;  nreq_d = nreq_in;
                    t_d = t_in;  l_d = l_in;  c_d = c_in;  tr_d = tr_in;
                    req_d = '0;  rsp_d = '0;
                    for (int i = 0; i < MAX_N; i++) begin
                        top_d[i]  = DEF;
                        left_d[i] = DEF;
                    end
                    trp_d   = {4{DEF}};
                    cor_d   = DEF;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (nreq_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    req_c = 1'b1;
                    req_d = req_q + CNT_W'(1);
                    if (req_last) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_d == nreq_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q <= '0;  y_q <= '0;  n_q <= '0;  nreq_q <= '0;
            req_q <= '0;  rsp_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;
            t_q <= 1'b0;  l_q <= 1'b0;  c_q <= 1'b0;  tr_q <= 1'b0;
            top_q <= '0;  left_q <= '0;  trp_q <= '0;  cor_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;  y_q <= y_d;  n_q <= n_d;  nreq_q <= nreq_d;
            req_q <= req_d;  rsp_q <= rsp_d;
            busy_q <= busy_d;  done_q <= done_d;
            t_q <= t_d;  l_q <= l_d;  c_q <= c_d;  tr_q <= tr_d;
            top_q <= top_d;  left_q <= left_d;  trp_q <= trp_d;  cor_q <= cor_d;
        end
    end

    assign mem.mem_req     = req_c;
    assign mem.mem_addr    = req_addr;
    assign busy            = busy_q;
    assign done            = done_q;
    assign toppixels       = top_q;
    assign leftpixels      = left_q;
    assign toprightpixels  = trp_q;
    assign cornerpixel     = cor_q;
    assign top_avail       = t_q;
    assign left_avail      = l_q;
    assign corner_avail    = c_q;
    assign topright_avail  = tr_q;

endmodule

// File: doc/neighbour_fetch.md
Name: neighbour_fetch

Overview:
- Sequential successor to the intra-prediction neighbour extractor.
- Fetches the top, left, top-left corner and optional top-right reconstructed pixels for one prediction block from a single-port frame-buffer read interface.
- Runtime block size is selectable: 16x16, 8x8 or 4x4. Availability flags are produced; pixels outside the frame are substituted without any memory read.
- Sits between the reconstructed-frame buffer and the intra predictors. Handshake is start/busy/done.

Parameters:
- PIX_W, 8, pixel bit width
- FRAME_W, 1280, frame width in pixels (row stride)
- FRAME_H, 720, frame height in pixels
- MAX_N, 16, largest block edge supported; sizes the output arrays
- ADDR_W, 20, frame-buffer address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H
- DEFAULT_PIX, 128, substitute value for unavailable neighbours

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only when busy=0
- blk_mode  in  2  0=16x16, 1=8x8, 2=4x4, 3=treated as 16x16
- pix_x  in  16  block top-left column in pixels
- pix_y  in  16  block top-left row in pixels
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when all outputs are valid
- mem_req  out  1  read request strobe
- mem_addr  out  ADDR_W  address = y*FRAME_W + x
- mem_rvalid  in  1  read data valid; responses return in request order; no backpressure
- mem_rdata  in  PIX_W  read data
- toppixels  out  PIX_W x MAX_N  row above the block, index 0 leftmost
- toprightpixels  out  PIX_W x 4  the 4 pixels right of the top row (4x4 mode)
- leftpixels  out  PIX_W x MAX_N  column left of the block, index 0 top
- cornerpixel  out  PIX_W  pixel at (x-1, y-1)
- top_avail, left_avail, corner_avail, topright_avail  out  1 each  availability flags

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, FSM to IDLE, request/response counters 0.
- Reset mid-operation aborts the fetch. Responses arriving after reset are ignored in IDLE.
- Block edge N = 16, 8 or 4 from blk_mode, latched together with pix_x and pix_y on start.
- Availability is computed at start:
  - top = (y>0)
  - left = (x>0)
  - corner = top && left
  - topright = top && mode==4x4 && (x+N+3 < FRAME_W)
- FSM states and transitions:
  - IDLE: on start, latch inputs, compute flags, go to ISSUE.
  - ISSUE: one mem_req per cycle, in this order:
    - corner (if available)
    - top[0..N-1] (if available)
    - topright[0..3] (if available)
    - left[0..N-1] (if available)
    - Unavailable groups are skipped; their slots are written immediately.
  - ISSUE goes to WAIT when the last request is issued, or straight to DONE if zero requests are needed.
  - WAIT: capture mem_rdata on each mem_rvalid. A response counter steers each response to its destination slot (same order as requests). mem_rvalid may coincide with ISSUE cycles.
  - WAIT goes to DONE when the response count equals the request count.
  - DONE: pulse done for 1 cycle, drop busy, return to IDLE.
- Substitution for unavailable pixels:
  - toppixels, leftpixels and cornerpixel take DEFAULT_PIX.
  - toprightpixels take toppixels[N-1] when top_avail, else DEFAULT_PIX.
- Array entries with index >= N are written DEFAULT_PIX.
- Address arithmetic is done at ADDR_W+1 bits; out-of-frame addresses are never issued.
- Outputs hold their values until the next accepted start.
- start while busy is ignored. mem_rvalid in IDLE is ignored.
- Latency with single-cycle memory and all groups available (16x16): 33 requests, done 35 cycles after start.

Optional Feature:
- Macro: NF_TOPRIGHT_EN.
- When defined: top-right fetch as described above.
- When undefined:
  - No top-right reads are issued and topright_avail is always 0.
  - toprightpixels are always filled by the substitution rule.
  - Request count shrinks by 4 in 4x4 mode.

Decomposition:
- Package nf_pkg holds:
  - blk_mode enum (MODE_16, MODE_8, MODE_4)
  - FSM state enum
  - function mode_to_n
  - slot-index constants for the corner/top/topright/left ordering
- One sub-module, nf_addr_gen: given latched x, y, N, flags and the request index, produces mem_addr, the destination slot and a last-request flag.

Test Plan:
- 16x16 at x=32, y=16, memory value = addr[7:0], 1-cycle latency -> 33 reads; toppixels[j] = ((15*1280)+32+j)[7:0]; left[i] = ((16+i)*1280+31)[7:0]; all flags 1; done at cycle 35.
- 4x4 at x=0, y=0 -> zero reads; all outputs 128; all flags 0; done 2 cycles after start.
- 4x4 at x=1276, y=4 -> topright_avail=0; toprightpixels = toppixels[3]; 9 reads (corner + 4 top + 4 left).
- 8x8 with random mem_rvalid latency 1-5 cycles -> values match the reference model; toppixels[8..15] = 128; start pulsed while busy is ignored.
- Reset asserted during WAIT, then a fresh 16x16 start -> stale responses discarded; outputs correct.
- NF_TOPRIGHT_EN undefined, 4x4 at x=16, y=16 -> 9 reads; topright_avail=0; toprightpixels = toppixels[3].
